// File: rtl/foo_pkg.sv
// Shared types for the foo result path.
package foo_pkg;

    localparam int unsigned FOO_X_W    = 64;
    localparam int unsigned FOO_LONG_W = 129;

    typedef struct packed {
        logic [FOO_LONG_W-1:0] long_v;
        logic [FOO_X_W-1:0]    x;
    } foo_result_t;

    typedef logic [31:0] foo_ts_t;

endpackage

// File: rtl/foo_result_mem.sv
// Entry storage for foo_result_buf: one synchronous write port, one asynchronous read port.
module foo_result_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/foo_result_buf.sv
// FWFT result buffer beside each foo lane, with saturating drop counter.
// Optional per-entry push timestamp enabled by defining FOO_RESULT_BUF_TS_EN.
module foo_result_buf
    import foo_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned OVF_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [FOO_X_W-1:0]       in_x,
    input  logic [FOO_LONG_W-1:0]    in_long,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FOO_X_W-1:0]       out_x,
    output logic [FOO_LONG_W-1:0]    out_long,
    output logic [31:0]              out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [OVF_W-1:0]         ovf_cnt
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned RES_W = $bits(foo_result_t);
    localparam int unsigned TS_W  = $bits(foo_ts_t);
`ifdef FOO_RESULT_BUF_TS_EN
    localparam int unsigned ENTRY_W = RES_W + TS_W;
`else
    localparam int unsigned ENTRY_W = RES_W;
`endif

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             out_valid_q, out_valid_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;

    logic             pop_c, push_c, drop_c;
    foo_result_t      in_res_c, head_res_c;
    logic [ENTRY_W-1:0] wdata_c, rdata_c;

    assign in_res_c.long_v = in_long;
    assign in_res_c.x      = in_x;

`ifdef FOO_RESULT_BUF_TS_EN
    foo_ts_t ts_q, ts_d;

    // Free-running cycle counter captured alongside each pushed entry.
    always_comb begin
        ts_d = ts_q + TS_W'(1);
    end

    // Timestamp counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign wdata_c = {ts_q, in_res_c};
    assign out_ts  = out_valid_q ? rdata_c[ENTRY_W-1 -: TS_W] : '0;
`else
    assign wdata_c = in_res_c;
    assign out_ts  = '0;
`endif

    assign head_res_c = rdata_c[RES_W-1:0];

    foo_result_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_c),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wdata_c),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rdata_c)
    );

    // Handshake decode and next-state for pointers, occupancy and drop counter.
    always_comb begin
        pop_c  = out_valid_q & out_ready;
        push_c = in_valid & (~full_q | pop_c);
        drop_c = in_valid & full_q & ~pop_c;

        wr_ptr_d = wr_ptr_q + PW'(push_c);
        rd_ptr_d = rd_ptr_q + PW'(pop_c);
        count_d  = count_q + PW'(push_c) - PW'(pop_c);

        out_valid_d = (wr_ptr_d != rd_ptr_d);
        full_d      = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);

        ovf_d = ovf_q;
        if (drop_c && (ovf_q != {OVF_W{1'b1}})) begin
            ovf_d = ovf_q + OVF_W'(1);
        end
    end

    // Control state registers; asynchronous reset empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_valid_q ? head_res_c.x : '0;
    assign out_long  = out_valid_q ? head_res_c.long_v : '0;
    assign count     = count_q;
    assign full      = full_q;
    assign ovf_cnt   = ovf_q;

endmodule

// File: tb/tb_foo_result_buf.sv
// Scoreboard bench for foo_result_buf: queue-based reference model, decoupled monitor.
module tb_foo_result_buf;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned OVF_W = 16;
`ifdef FOO_RESULT_BUF_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid;
    logic [63:0]    in_x;
    logic [128:0]   in_long;
    logic           out_valid;
    logic           out_ready;
    logic [63:0]    out_x;
    logic [128:0]   out_long;
    logic [31:0]    out_ts;
    logic [3:0]     count;
    logic           full;
    logic [15:0]    ovf_cnt;

    foo_result_buf #(.DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_long   (in_long),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_long  (out_long),
        .out_ts    (out_ts),
        .count     (count),
        .full      (full),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  x;
        logic [128:0] lg;
        logic [31:0]  ts;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          mq_cnt = 0;
    logic [15:0] mdl_ovf = '0;
    logic [31:0] ts_mdl  = '0;
    bit          mon_en  = 1'b0;

    // Model-predicted visible state for the current cycle.
    bit          snap_valid = 1'b0;
    int          snap_cnt   = 0;
    bit          snap_full  = 1'b0;
    logic [15:0] snap_ovf   = '0;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    function automatic logic [128:0] rlong();
        return {1'($urandom), $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [63:0] rx();
        return {$urandom, $urandom};
    endfunction

    // Drive one cycle of stimulus, advance the reference model, then move to the next cycle.
    task automatic step(input bit iv, input bit ordy, input logic [63:0] x, input logic [128:0] lg);
        bit pop, push;
        exp_t e;
        in_valid  = iv;
        out_ready = ordy;
        in_x      = x;
        in_long   = lg;
        snap_valid = (mq_cnt != 0);
        snap_cnt   = mq_cnt;
        snap_full  = (mq_cnt == DEPTH);
        snap_ovf   = mdl_ovf;
        pop  = snap_valid && ordy;
        push = iv && ((mq_cnt < DEPTH) || pop);
        if (iv && !push && mdl_ovf != 16'hFFFF) mdl_ovf = mdl_ovf + 16'd1;
        if (push) begin
            e.x  = x;
            e.lg = lg;
            e.ts = TS_EN ? ts_mdl : 32'd0;
            exp_q.push_back(e);
        end
        mq_cnt = mq_cnt + int'(push) - int'(pop);
        ts_mdl = ts_mdl + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        mq_cnt  = 0;
        mdl_ovf = '0;
        ts_mdl  = '0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: compare visible state each cycle and pop the scoreboard on each accepted output.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst) begin
            chk("out_valid", 192'(out_valid), 192'(snap_valid));
            chk("count", 192'(count), 192'(snap_cnt));
            chk("full", 192'(full), 192'(snap_full));
            chk("ovf_cnt", 192'(ovf_cnt), 192'(snap_ovf));
            if (!out_valid) begin
                chk("out_x_gated", 192'(out_x), 192'(0));
                chk("out_long_gated", 192'(out_long), 192'(0));
                chk("out_ts_gated", 192'(out_ts), 192'(0));
            end else if (out_ready) begin
                chk("sb_nonempty", 192'(exp_q.size() != 0), 192'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_x", 192'(out_x), 192'(e.x));
                    chk("out_long", 192'(out_long), 192'(e.lg));
                    chk("out_ts", 192'(out_ts), 192'(e.ts));
                end
            end
        end
    end

    initial begin
        in_x    = '0;
        in_long = '0;
        do_reset();
        chk("rst_count", 192'(count), 192'(0));
        chk("rst_valid", 192'(out_valid), 192'(0));
        chk("rst_full", 192'(full), 192'(0));
        chk("rst_ovf", 192'(ovf_cnt), 192'(0));
        mon_en = 1'b1;

        // Single push, latency one cycle, no bypass.
        step(1'b0, 1'b1, '0, '0);
        step(1'b1, 1'b1, 64'd5, rlong());
        chk("t1_valid", 192'(out_valid), 192'(1));
        chk("t1_x", 192'(out_x), 192'(5));
        step(1'b0, 1'b1, '0, '0);
        chk("t1_empty", 192'(out_valid), 192'(0));
        chk("t1_count", 192'(count), 192'(0));

        // Fill, overflow by one, drain in order.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 64'(10 * (i + 1)), rlong());
        chk("t2_full", 192'(full), 192'(1));
        chk("t2_count8", 192'(count), 192'(8));
        step(1'b1, 1'b0, 64'd90, rlong());
        chk("t2_ovf", 192'(ovf_cnt), 192'(1));
        chk("t2_count", 192'(count), 192'(8));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, '0);
        chk("t2_drained", 192'(exp_q.size()), 192'(0));
        chk("t2_empty", 192'(out_valid), 192'(0));

        // Push and pop while full across three laps.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 64'(200 + i), rlong());
        for (int i = 0; i < 3 * DEPTH; i++) step(1'b1, 1'b1, 64'(300 + i), rlong());
        chk("t3_count", 192'(count), 192'(8));
        chk("t3_ovf", 192'(ovf_cnt), 192'(1));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, '0);

        // Reset asserted mid-cycle with held entries.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'(500 + i), rlong());
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t4_valid", 192'(out_valid), 192'(0));
        chk("t4_count", 192'(count), 192'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b1, 64'd7, rlong());
        chk("t4_first", 192'(out_x), 192'(7));
        step(1'b0, 1'b1, '0, '0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(9) < 6), ($urandom_range(1) == 1), rx(), rlong());
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, '0, '0);
        chk("rnd_drained", 192'(exp_q.size()), 192'(0));

        // Timestamps at cycles 4 and 9 after reset.
        do_reset();
        for (int c = 0; c < 12; c++)
            step((c == 4) || (c == 9), 1'b0, 64'(c), rlong());
        chk("t6_ts_head", 192'(out_ts), 192'(TS_EN ? 4 : 0));
        step(1'b0, 1'b1, '0, '0);
        chk("t6_ts_second", 192'(out_ts), 192'(TS_EN ? 9 : 0));
        step(1'b0, 1'b1, '0, '0);

        // Saturating drop counter.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, rx(), rlong());
        for (int i = 0; i < 65536 + 3; i++) step(1'b1, 1'b0, 64'(i), '0);
        chk("t5_ovf_sat", 192'(ovf_cnt), 192'(16'hFFFF));
        chk("t5_count", 192'(count), 192'(8));

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
